// File: rtl/tw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tw_pkg
// Description : Shared FSM encoding and quarter-wave sine table builder for
//               the FFT twiddle generator.
// Revision    : 1.0
// ============================================================================
package tw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tw_state_e;

    localparam int     c_frac    = 28;
    localparam longint c_one_q28 = 64'sd1 << c_frac;
    localparam longint c_pi_q28  = 64'sd843314856;

    // round(2^(wl-2) * sin(2*pi*idx/2^log2n)) via Q28 Taylor series, so
    // the table folds to constants without relying on real-valued math.
    function automatic int q_entry(input int log2n, input int wl, input int idx);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (c_pi_q28 * 2 * longint'(idx)) >>> log2n;
        x2   = (x * x) / c_one_q28;
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -(((term * x2) / c_one_q28) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        return int'((acc * (longint'(1) << (wl - 2)) + (c_one_q28 >>> 1)) >>> c_frac);
    endfunction

endpackage : tw_pkg
`default_nettype wire

// File: rtl/tw_quarter_rom.sv
`default_nettype none
// ============================================================================
// Module      : tw_quarter_rom
// Description : Dual-read N/4+1 entry quarter-wave sine table, registered read.
// Revision    : 1.0
// ============================================================================
module tw_quarter_rom
    import tw_pkg::*;
#(
    parameter int LOG2N = 8,
    parameter int WL    = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [LOG2N-2:0]     addr_a,
    input  logic [LOG2N-2:0]     addr_b,
    output logic signed [WL-1:0] q_a,
    output logic signed [WL-1:0] q_b
);

    localparam int c_depth = (1 << (LOG2N - 2)) + 1;

    logic signed [WL-1:0] w_rom [0:c_depth-1];

    for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
        localparam logic signed [WL-1:0] c_q = WL'(q_entry(LOG2N, WL, gi));
        assign w_rom[gi] = c_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a <= '0;
            q_b <= '0;
        end else if (en) begin
            q_a <= w_rom[addr_a];
            q_b <= w_rom[addr_b];
        end
    end

endmodule : tw_quarter_rom
`default_nettype wire

// File: rtl/tw_factor_gen.sv
`default_nettype none
// ============================================================================
// Module      : tw_factor_gen
// Description : Radix-2 FFT/IFFT twiddle sequencer with 2-stage stallable
//               pipeline over a quarter-wave table.
// Revision    : 1.0
// ============================================================================
module tw_factor_gen
    import tw_pkg::*;
#(
    parameter int LOG2N = 8,
    parameter int WL    = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(LOG2N)-1:0]   stage,
    input  logic                       inverse,
    input  logic                       rdy_in,
    output logic                       busy,
    output logic                       tw_valid,
    output logic signed [WL-1:0]       cos_data,
    output logic signed [WL-1:0]       sin_data,
    output logic                       tw_last,
    output logic                       done,
    output logic                       err
);

    localparam int c_sw = $clog2(LOG2N);
    localparam int c_kw = LOG2N - 1;
    localparam logic [c_kw-1:0] c_quarter = c_kw'(1 << (LOG2N - 2));
    localparam logic [c_kw-1:0] c_ones    = '1;

    tw_state_e            r_state;
    logic [c_kw-1:0]      r_k;
    logic [c_sw-1:0]      r_s;
    logic                 r_inv;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 r_valid1;
    logic                 r_last1;
    logic [c_kw-1:0]      r_cos_addr1;
    logic [c_kw-1:0]      r_sin_addr1;
    logic                 r_cos_neg1;
    logic                 r_sin_neg1;
    logic                 r_valid2;
    logic                 r_last2;
    logic                 r_cos_neg2;
    logic                 r_sin_neg2;

    logic                 w_adv;
    logic                 w_issue;
    logic                 w_accept_last;
    logic [c_kw-1:0]      w_mask;
    logic [c_sw-1:0]      w_shamt;
    logic [c_kw-1:0]      w_e;
    logic [c_kw-1:0]      w_cos_addr;
    logic [c_kw-1:0]      w_sin_addr;
    logic                 w_cos_neg;
    logic signed [WL-1:0] w_cos_q;
    logic signed [WL-1:0] w_sin_q;

    assign w_adv         = ~r_valid2 | rdy_in;
    assign w_issue       = (r_state == ST_RUN) && w_adv;
    assign w_accept_last = r_valid2 && r_last2 && rdy_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_s     <= '0;
            r_inv   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (32'(stage) < LOG2N) begin
                            r_s     <= stage;
                            r_inv   <= inverse;
                            r_k     <= '0;
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_adv) begin
                        r_k <= r_k + 1'b1;
                        if (r_k == c_ones) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_accept_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A shift of c_kw clears the all-ones word, so the last stage masks nothing.
    assign w_mask  = ~(c_ones << r_s);
    assign w_shamt = c_sw'(c_kw) - r_s;
    assign w_e     = (r_k & w_mask) << w_shamt;

    always_comb begin
        w_cos_addr = '0;
        w_sin_addr = '0;
        w_cos_neg  = 1'b0;
        if (w_e <= c_quarter) begin
            w_cos_addr = c_quarter - w_e;
            w_sin_addr = w_e;
        end else begin
            w_cos_addr = w_e - c_quarter;
            w_cos_neg  = 1'b1;
            // N/2 is 2^c_kw, so N/2 - e wraps to the two's complement of e.
            w_sin_addr = -w_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid1    <= 1'b0;
            r_last1     <= 1'b0;
            r_cos_addr1 <= '0;
            r_sin_addr1 <= '0;
            r_cos_neg1  <= 1'b0;
            r_sin_neg1  <= 1'b0;
            r_valid2    <= 1'b0;
            r_last2     <= 1'b0;
            r_cos_neg2  <= 1'b0;
            r_sin_neg2  <= 1'b0;
        end else if (w_adv) begin
            r_valid1 <= w_issue;
            r_last1  <= w_issue && (r_k == c_ones);
            if (w_issue) begin
                r_cos_addr1 <= w_cos_addr;
                r_sin_addr1 <= w_sin_addr;
                r_cos_neg1  <= w_cos_neg;
                r_sin_neg1  <= ~r_inv;
            end
            r_valid2   <= r_valid1;
            r_last2    <= r_last1;
            r_cos_neg2 <= r_cos_neg1;
            r_sin_neg2 <= r_sin_neg1;
        end
    end

    tw_quarter_rom #(
        .LOG2N (LOG2N),
        .WL    (WL)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (w_adv),
        .addr_a (r_cos_addr1),
        .addr_b (r_sin_addr1),
        .q_a    (w_cos_q),
        .q_b    (w_sin_q)
    );

    assign cos_data = r_cos_neg2 ? -w_cos_q : w_cos_q;
    assign sin_data = r_sin_neg2 ? -w_sin_q : w_sin_q;
    assign tw_valid = r_valid2;
    assign tw_last  = r_last2;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule : tw_factor_gen
`default_nettype wire

// File: tb/tb_tw_factor_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tw_factor_gen
// Description : Directed vector bench for tw_factor_gen (N=256 main, N=64 aux).
// Revision    : 1.0
// ============================================================================
module tb_tw_factor_gen;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [2:0]         stage;
    logic               inverse;
    logic               rdy_in;
    logic               busy;
    logic               tw_valid;
    logic signed [13:0] cos_data;
    logic signed [13:0] sin_data;
    logic               tw_last;
    logic               done;
    logic               err;

    logic               start_b;
    logic [2:0]         stage_b;
    logic               inverse_b;
    logic               rdy_b;
    logic               busy_b;
    logic               valid_b;
    logic signed [13:0] cos_b;
    logic signed [13:0] sin_b;
    logic               last_b;
    logic               done_b;
    logic               err_b;

    int n_vec;
    int n_bad;
    int cap_cos [6][128];
    int cap_sin [6][128];

    typedef struct {
        int run;
        int k;
        int cos_e;
        int sin_e;
    } vec_t;
    vec_t vecs[$];

    tw_factor_gen #(.LOG2N(8), .WL(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stage(stage), .inverse(inverse),
        .rdy_in(rdy_in), .busy(busy), .tw_valid(tw_valid), .cos_data(cos_data),
        .sin_data(sin_data), .tw_last(tw_last), .done(done), .err(err)
    );

    // Small instance where out-of-range stage values are representable.
    tw_factor_gen #(.LOG2N(6), .WL(14)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stage(stage_b), .inverse(inverse_b),
        .rdy_in(rdy_b), .busy(busy_b), .tw_valid(valid_b), .cos_data(cos_b),
        .sin_data(sin_b), .tw_last(last_b), .done(done_b), .err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    task automatic model(input int s, input int k, input bit inv, output int c, output int sn);
        int  e;
        real th;
        int  m;
        e  = (k & ((1 << s) - 1)) << (7 - s);
        th = 2.0 * 3.14159265358979 * real'(e) / 256.0;
        c  = rnd(4096.0 * $cos(th));
        m  = rnd(4096.0 * $sin(th));
        sn = inv ? m : -m;
    endtask

    task automatic run_seq(input int run, input int s, input bit inv, input bit rnd_rdy,
                           input bit poke, input bit immediate);
        int cnt, it, first_it, last_it, dones, errs, ec, es;
        bit stalled;
        int pc, ps, pl;
        if (!immediate) @(negedge clk);
        start   = 1'b1;
        stage   = 3'(s);
        inverse = inv;
        @(negedge clk);
        start   = 1'b0;
        stage   = 3'd0;
        inverse = ~inv;
        chk("busy_after_start", int'(busy), 1);
        cnt = 0; it = 0; first_it = -1; last_it = 0; dones = 0; errs = 0;
        stalled = 1'b0; pc = 0; ps = 0; pl = 0;
        while (cnt < 128 && it < 3000) begin
            @(negedge clk);
            if (poke && it == 10) begin
                start = 1'b1;
                stage = 3'd0;
            end else if (poke && it == 11) begin
                start = 1'b0;
            end
            if (stalled) begin
                chk("stall_valid", int'(tw_valid), 1);
                chk("stall_cos", int'(cos_data), pc);
                chk("stall_sin", int'(sin_data), ps);
                chk("stall_last", int'(tw_last), pl);
            end
            dones += int'(done);
            errs  += int'(err);
            rdy_in = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tw_valid && first_it < 0) first_it = it;
            if (tw_valid && rdy_in) begin
                model(s, cnt, inv, ec, es);
                chk($sformatf("cos r%0d k%0d", run, cnt), int'(cos_data), ec);
                chk($sformatf("sin r%0d k%0d", run, cnt), int'(sin_data), es);
                chk($sformatf("last r%0d k%0d", run, cnt), int'(tw_last), int'(cnt == 127));
                cap_cos[run][cnt] = int'(cos_data);
                cap_sin[run][cnt] = int'(sin_data);
                last_it = it;
                cnt++;
            end
            stalled = tw_valid && !rdy_in;
            pc = int'(cos_data);
            ps = int'(sin_data);
            pl = int'(tw_last);
            it++;
        end
        chk("accepted_count", cnt, 128);
        chk("first_valid_latency", first_it, 1);
        if (!rnd_rdy) chk("no_gaps", last_it - first_it, 127);
        @(negedge clk);
        rdy_in = 1'b1;
        chk("done_pulse", int'(done), 1);
        chk("busy_at_done", int'(busy), 0);
        chk("valid_after_done", int'(tw_valid), 0);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("early_done", dones, 0);
        chk("err_during_run", errs, 0);
    endtask

    initial begin
        int cnt, it;
        n_vec = 0;
        n_bad = 0;
        vecs.push_back('{0, 0, 4096, 0});
        vecs.push_back('{0, 127, 4096, 0});
        vecs.push_back('{1, 32, 2896, -2896});
        vecs.push_back('{1, 64, 0, -4096});
        vecs.push_back('{1, 96, -2896, -2896});
        vecs.push_back('{1, 1, 4095, -101});
        vecs.push_back('{1, 127, -4095, -101});
        vecs.push_back('{2, 32, 2896, 2896});
        vecs.push_back('{2, 64, 0, 4096});
        vecs.push_back('{2, 96, -2896, 2896});
        vecs.push_back('{3, 0, 4096, 0});
        vecs.push_back('{3, 1, 2896, -2896});
        vecs.push_back('{3, 2, 0, -4096});
        vecs.push_back('{3, 3, -2896, -2896});
        vecs.push_back('{3, 7, -2896, -2896});
        vecs.push_back('{4, 16, 2896, 2896});
        vecs.push_back('{4, 100, -799, 4017});
        vecs.push_back('{5, 40, 2276, -3406});

        rst_n = 1'b0; start = 1'b0; stage = 3'd0; inverse = 1'b0; rdy_in = 1'b1;
        start_b = 1'b0; stage_b = 3'd0; inverse_b = 1'b0; rdy_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(tw_valid), 0);
        chk("rst_cos", int'(cos_data), 0);
        chk("rst_sin", int'(sin_data), 0);
        chk("rst_done_err", int'({done, err, tw_last}), 0);
        rst_n = 1'b1;

        // Out-of-range stage requests on the N=64 instance.
        for (int v = 6; v < 8; v++) begin
            @(negedge clk);
            start_b = 1'b1;
            stage_b = 3'(v);
            @(negedge clk);
            start_b = 1'b0;
            chk($sformatf("err_pulse s%0d", v), int'(err_b), 1);
            chk($sformatf("err_busy s%0d", v), int'(busy_b), 0);
            @(negedge clk);
            chk($sformatf("err_clear s%0d", v), int'(err_b), 0);
            chk($sformatf("err_idle s%0d", v), int'(busy_b), 0);
        end
        @(negedge clk);
        start_b = 1'b1;
        stage_b = 3'd5;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_busy", int'(busy_b), 1);
        chk("b_no_err", int'(err_b), 0);
        cnt = 0;
        it  = 0;
        while (!done_b && it < 200) begin
            if (valid_b) cnt++;
            @(negedge clk);
            it++;
        end
        chk("b_done_seen", int'(done_b), 1);
        chk("b_count", cnt, 32);

        run_seq(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(1, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(2, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        run_seq(3, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_seq(4, 6, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a stage-7 run while k=40 is presented.
        @(negedge clk);
        start = 1'b1; stage = 3'd7; inverse = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        it  = 0;
        while (it < 400) begin
            @(negedge clk);
            if (tw_valid) begin
                if (cnt == 40) break;
                cnt++;
            end
            it++;
        end
        chk("reached_k40", cnt, 40);
        chk("k40_cos_before_reset", int'(cos_data), 2276);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(tw_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_cos", int'(cos_data), 0);
        chk("arst_sin", int'(sin_data), 0);
        chk("arst_last_done_err", int'({tw_last, done, err}), 0);
        @(negedge clk);
        chk("arst_no_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(5, 7, 1'b0, 1'b0, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            chk($sformatf("vec%0d cos", i), cap_cos[vecs[i].run][vecs[i].k], vecs[i].cos_e);
            chk($sformatf("vec%0d sin", i), cap_sin[vecs[i].run][vecs[i].k], vecs[i].sin_e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_tw_factor_gen
`default_nettype wire
